// File: rtl/pipeline_result_collector.sv
// Credit-based result collector at the tail of a fixed-latency pipeline.
// Optional fall-through path from result to out_data when COLLECTOR_BYPASS_EN is defined.
module pipeline_result_collector #(
  parameter int LATENCY   = 4,
  parameter int WORD_SIZE = 18,
  parameter int DEPTH     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         result_valid,
  input  logic [WORD_SIZE-1:0]         result,
  output logic                         out_valid,
  output logic [WORD_SIZE-1:0]         out_data,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   credits
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] head_q;
  logic [PW-1:0]        rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]        count, after_pop, count_next;
  logic [LATENCY-1:0]   issue_hist;
  logic                 empty, full, bypass, fire, pop, fifo_pop, write_en;

  assign empty = (count == '0);
  assign full  = (count == FULL);

`ifdef COLLECTOR_BYPASS_EN
  assign bypass   = empty && result_valid && out_ready;
  assign out_data = bypass ? result : head_q;
`else
  assign bypass   = 1'b0;
  assign out_data = head_q;
`endif

  assign out_valid   = !empty || bypass;
  assign issue_ready = (credits != '0);
  assign fire        = issue_valid && issue_ready;
  assign pop         = out_valid && out_ready;
  assign fifo_pop    = !empty && out_ready;
  // A full FIFO still accepts a result if the head leaves in the same cycle.
  assign write_en    = result_valid && !bypass && (!full || fifo_pop);
  assign rd_next     = fifo_pop ? ((rd_ptr == LAST) ? '0 : rd_ptr + 1'b1) : rd_ptr;
  assign after_pop   = count - CW'(fifo_pop);
  assign count_next  = after_pop + CW'(write_en);

  always_ff @(posedge clock) begin
    if (reset) begin
      credits    <= FULL;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_q     <= '0;
      overflow   <= 1'b0;
      issue_hist <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase

      if (write_en) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;

      if (result_valid && full && !fifo_pop)
        overflow <= 1'b1;

      // head_q mirrors the next head; it falls back to holding its value once drained.
      if (write_en && (after_pop == '0))
        head_q <= result;
      else if (count_next != '0)
        head_q <= mem[rd_next];
      else if (bypass)
        head_q <= result;

      issue_hist <= (issue_hist << 1) | LATENCY'(fire);
      if (issue_hist[LATENCY-1])
        assert (result_valid);
    end
  end

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Self-checking bench: emulates the upstream pipeline and compares the collector against a queue model.
module tb_pipeline_result_collector;

  localparam int LATENCY   = 4;
  localparam int WORD_SIZE = 18;
  localparam int DEPTH     = 8;
  localparam int CW        = $clog2(DEPTH + 1);
`ifdef COLLECTOR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 issue_valid, issue_ready;
  logic                 result_valid;
  logic [WORD_SIZE-1:0] result;
  logic                 out_valid, out_ready, overflow;
  logic [WORD_SIZE-1:0] out_data;
  logic [CW-1:0]        credits;

  logic [WORD_SIZE-1:0] issue_data;
  logic                 force_rv;
  logic [WORD_SIZE-1:0] force_data;
  logic                 pipe_v [LATENCY];
  logic [WORD_SIZE-1:0] pipe_d [LATENCY];

  logic [WORD_SIZE-1:0] model_q [$];
  int                   outstanding;
  bit                   ovf_m;
  logic [WORD_SIZE-1:0] last_m;
  int                   checks, errors, cyc;
  int                   hs_cyc [$];
  logic [WORD_SIZE-1:0] hs_dat [$];
  int                   fire_cyc [$];

  typedef struct {
    bit                   iv;
    bit                   ordy;
    logic [WORD_SIZE-1:0] data;
    bit                   exp_ready;
    bit                   exp_valid;
    int                   exp_credits;
    logic [WORD_SIZE-1:0] exp_data;
  } vec_t;
  vec_t tbl [15];

  assign result_valid = pipe_v[LATENCY-1] | force_rv;
  assign result       = force_rv ? force_data : pipe_d[LATENCY-1];

  always #5 clock = ~clock;

  pipeline_result_collector #(
    .LATENCY(LATENCY), .WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .result_valid(result_valid), .result(result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .overflow(overflow), .credits(credits)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: compare at negedge against the model, then advance model and pipeline after posedge.
  task automatic applyStimulus();
    bit                   rv, exp_ready, byp, exp_valid, fire, pop, was_full;
    logic [WORD_SIZE-1:0] rd, exp_data;
    int                   sz;
    @(negedge clock);
    rv        = pipe_v[LATENCY-1] || force_rv;
    rd        = force_rv ? force_data : pipe_d[LATENCY-1];
    sz        = model_q.size();
    exp_ready = outstanding < DEPTH;
    byp       = BYPASS && sz == 0 && rv && out_ready;
    exp_valid = (sz > 0) || byp;
    exp_data  = byp ? rd : ((sz > 0) ? model_q[0] : last_m);
    checkOutput("issue_ready", 32'(issue_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    checkOutput("out_data", 32'(out_data), 32'(exp_data));
    checkOutput("overflow", 32'(overflow), 32'(ovf_m));
    checkOutput("credits", 32'(credits), 32'(DEPTH - outstanding));
    if (out_valid === 1'b1 && out_ready) begin
      hs_cyc.push_back(cyc);
      hs_dat.push_back(out_data);
    end
    fire     = issue_valid && exp_ready && !reset;
    pop      = exp_valid && out_ready;
    was_full = (sz == DEPTH);
    if (fire) fire_cyc.push_back(cyc);
    @(posedge clock);
    #1;
    if (reset) begin
      model_q.delete();
      outstanding = 0;
      ovf_m       = 1'b0;
      last_m      = '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] = 1'b0;
        pipe_d[i] = '0;
      end
    end else begin
      outstanding += int'(fire) - int'(pop);
      if (exp_valid) last_m = exp_data;
      if (pop && !byp) void'(model_q.pop_front());
      if (rv && !byp) begin
        if (was_full && !pop) ovf_m = 1'b1;
        else model_q.push_back(rd);
      end
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = fire;
      pipe_d[0] = issue_data;
    end
    cyc++;
  endtask

  task automatic drive(input bit iv, input bit ordy, input logic [WORD_SIZE-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      issue_valid = iv;
      out_ready   = ordy;
      issue_data  = d + WORD_SIZE'(k);
      applyStimulus();
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; issue_data = '0;
    force_rv = 1'b0; force_data = '0;
    for (int i = 0; i < LATENCY; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    outstanding = 0; ovf_m = 1'b0; last_m = '0;

    // Reset, then eight back-to-back issues with the consumer stalled, then blocked issues.
    for (int r = 0; r < 15; r++) begin
      tbl[r].iv          = (r >= 1);
      tbl[r].ordy        = 1'b0;
      tbl[r].data        = WORD_SIZE'(r);
      tbl[r].exp_credits = (r <= 1) ? 8 : ((r <= 9) ? 9 - r : 0);
      tbl[r].exp_ready   = (tbl[r].exp_credits != 0);
      tbl[r].exp_valid   = (r >= 6);
      tbl[r].exp_data    = (r >= 6) ? WORD_SIZE'(1) : '0;
    end

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int r = 0; r < 15; r++) begin
      issue_valid = tbl[r].iv;
      out_ready   = tbl[r].ordy;
      issue_data  = tbl[r].data;
      #1;
      checkOutput("tbl_credits", 32'(credits), 32'(tbl[r].exp_credits));
      checkOutput("tbl_issue_ready", 32'(issue_ready), 32'(tbl[r].exp_ready));
      checkOutput("tbl_out_valid", 32'(out_valid), 32'(tbl[r].exp_valid));
      checkOutput("tbl_out_data", 32'(out_data), 32'(tbl[r].exp_data));
      applyStimulus();
    end
    checkOutput("full_overflow", 32'(overflow), 32'(0));

    // Full FIFO: pop and keep issuing, the freed credit is reused at once.
    drive(1'b1, 1'b1, 18'h00100, 1);
    drive(1'b1, 1'b0, 18'h00101, 1);
    drive(1'b0, 1'b0, '0, 7);
    checkOutput("refill_credits", 32'(credits), 32'(0));
    checkOutput("refill_overflow", 32'(overflow), 32'(0));

    // Protocol violation: an extra result into a full FIFO.
    force_rv = 1'b1; force_data = 18'h3ABCD;
    drive(1'b0, 1'b0, '0, 1);
    force_rv = 1'b0;
    drive(1'b0, 1'b0, '0, 1);
    checkOutput("overflow_set", 32'(overflow), 32'(1));
    drive(1'b0, 1'b1, '0, 10);
    checkOutput("overflow_sticky", 32'(overflow), 32'(1));

    // Latency of isolated results through an empty FIFO.
    hs_cyc.delete(); hs_dat.delete(); fire_cyc.delete();
    drive(1'b1, 1'b1, 18'h00001, 5);
    drive(1'b0, 1'b1, '0, 12);
    checkOutput("lat_count", 32'(hs_cyc.size()), 32'(5));
    for (int i = 0; i < 5 && i < hs_cyc.size() && i < fire_cyc.size(); i++) begin
      checkOutput("lat_data", 32'(hs_dat[i]), 32'(i + 1));
      checkOutput("lat_cycles", 32'(hs_cyc[i] - fire_cyc[i]), 32'(BYPASS ? LATENCY : LATENCY + 1));
    end
    checkOutput("lat_credits", 32'(credits), 32'(DEPTH));

    // Reset with three stored and two in flight.
    drive(1'b1, 1'b0, 18'h00200, 5);
    drive(1'b0, 1'b0, '0, 2);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1);
    reset = 1'b0;
    hs_cyc.delete(); hs_dat.delete();
    #1;
    checkOutput("rst_credits", 32'(credits), 32'(DEPTH));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_overflow", 32'(overflow), 32'(0));
    drive(1'b0, 1'b1, '0, 10);
    checkOutput("rst_no_results", 32'(hs_cyc.size()), 32'(0));

    // Random traffic with varying consumer duty cycle.
    for (int i = 0; i < 400; i++) begin
      issue_valid = ($urandom_range(3) != 0);
      out_ready   = (i < 200) ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0);
      issue_data  = WORD_SIZE'($urandom);
      applyStimulus();
    end
    drive(1'b0, 1'b1, '0, 20);
    checkOutput("final_credits", 32'(credits), 32'(DEPTH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
